// File: rtl/ccd_frame_capture.sv
// CCD/AFE frame grabber: crops an active window from each armed frame and streams
// the pixels through a small first-word-fall-through FIFO as 16-bit valid/ready words.
module ccd_frame_capture #(
  parameter int unsigned DW       = 14,
  parameter int unsigned COL_SKIP = 16,
  parameter int unsigned COL_ACT  = 640,
  parameter int unsigned ROW_SKIP = 4,
  parameter int unsigned ROW_ACT  = 480,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [DW-1:0] afe_d,
  input  logic          afe_hd,
  input  logic          afe_vd,
  output logic [15:0]   pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow,
  output logic          frame_err,
  input  logic          clr_err
);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME, DONE} state_t;

  localparam logic [15:0] COL_LO = 16'(COL_SKIP);
  localparam logic [15:0] COL_HI = 16'(COL_SKIP + COL_ACT - 1);
  localparam logic [15:0] ROW_LO = 16'(ROW_SKIP);
  localparam logic [15:0] ROW_HI = 16'(ROW_SKIP + ROW_ACT - 1);
  localparam int unsigned DEPTH  = 2 ** FIFO_AW;

  state_t state, state_nx;

  logic [DW-1:0] d_r;
  logic          hd_r, hd_p, vd_r, vd_p;
  logic          hd_fall, vd_fall;
  logic [15:0]   col, row;
  logic          line_seen;
  logic          in_win, cap, last_px, frame_abort;

  logic [17:0]       mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic [17:0]       head, last_q;
  logic              empty, full, pop, wr_en;

  // Syncs reset to their inactive (high) level so release cannot fake an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_r  <= '0;
      hd_r <= 1'b1;
      hd_p <= 1'b1;
      vd_r <= 1'b1;
      vd_p <= 1'b1;
    end else begin
      d_r  <= afe_d;
      hd_r <= afe_hd;
      hd_p <= hd_r;
      vd_r <= afe_vd;
      vd_p <= vd_r;
    end
  end

  assign hd_fall = hd_p & ~hd_r;
  assign vd_fall = vd_p & ~vd_r;

  // line_seen keeps pixels ahead of the first HD of a frame out of the window.
  always_comb begin
    in_win  = line_seen && (row >= ROW_LO) && (row <= ROW_HI) &&
              (col >= COL_LO) && (col <= COL_HI);
    cap     = (state == FRAME) && in_win;
    last_px = (row == ROW_HI) && (col == COL_HI);
  end

  always_comb begin
    state_nx    = state;
    frame_abort = 1'b0;
    case (state)
      IDLE:  if (arm) state_nx = ARMED;
      ARMED: if (vd_fall) state_nx = FRAME;
      FRAME: begin
        if (cap && last_px) begin
          state_nx = DONE;
        end else if (vd_fall) begin
          state_nx    = IDLE;
          frame_abort = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      line_seen <= 1'b0;
    end else if (state == ARMED && vd_fall) begin
      row       <= '0;
      line_seen <= 1'b0;
    end else if (state == FRAME) begin
      if (hd_fall) begin
        col       <= '0;
        line_seen <= 1'b1;
        if (line_seen && row != '1) row <= row + 16'd1;
      end else if (col != '1) begin
        col <= col + 16'd1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = !empty && pix_ready;
  assign wr_en = cap && (!full || pop);
  // When empty the outputs show the last word handed out, not a stale RAM slot.
  assign head  = empty ? last_q : mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[FIFO_AW-1:0]] <= {(row == ROW_LO) && (col == COL_LO), col == COL_HI, 16'(d_r)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_q    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= head;
      end
      if (cap && full && !pop) overflow <= 1'b1;
      else if (clr_err)        overflow <= 1'b0;
      if (frame_abort)         frame_err <= 1'b1;
      else if (clr_err)        frame_err <= 1'b0;
    end
  end

  assign pix_valid  = !empty;
  assign pix_data   = head[15:0];
  assign pix_sof    = head[17];
  assign pix_eol    = head[16];
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed bench for ccd_frame_capture using a 4x2 window (skip 2 cols, 1 row), 4-deep FIFO.
module tb_ccd_frame_capture;

  logic        clk = 1'b0;
  logic        rst, arm, afe_hd, afe_vd, pix_ready, clr_err;
  logic [13:0] afe_d;
  logic [15:0] pix_data;
  logic        pix_sof, pix_eol, pix_valid, busy, frame_done, overflow, frame_err;

  int total = 0;
  int bad   = 0;
  int done_cnt, valid_seen, busy_seen;
  logic [17:0] got_q[$];
  logic [17:0] exp_tab[8];

  always #5 clk = ~clk;

  ccd_frame_capture #(
    .DW(14), .COL_SKIP(2), .COL_ACT(4), .ROW_SKIP(1), .ROW_ACT(2), .FIFO_AW(2)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .afe_d(afe_d), .afe_hd(afe_hd), .afe_vd(afe_vd),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  // Inputs change 2 time units after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_sof, pix_eol, pix_data});
    if (frame_done) done_cnt++;
    if (pix_valid) valid_seen++;
    if (busy) busy_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic hd, input logic vd, input logic [13:0] d);
    afe_hd = hd;
    afe_vd = vd;
    afe_d  = d;
    @(posedge clk);
    #2;
  endtask

  // mode: 0 plain, 1 arm pulse mid-frame, 2 VD abort, 3 reset mid-frame, 4 overflow timing
  task automatic run_frame(input bit do_arm, input int mode);
    if (do_arm) begin
      arm = 1'b1;
      cyc(1'b1, 1'b1, 14'd0);
      arm = 1'b0;
    end
    cyc(1'b1, 1'b1, 14'd0);
    cyc(1'b1, 1'b0, 14'd0);
    cyc(1'b1, 1'b1, 14'd0);
    cyc(1'b1, 1'b1, 14'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic vd;
        vd = 1'b1;
        if (mode == 1 && r == 1 && c == 5) arm = 1'b1;
        if (mode == 2 && r == 1 && c == 5) vd = 1'b0;
        if (mode == 3 && r == 1 && c == 6) begin
          rst = 1'b0;
          #1;
          check("t5_busy_async", busy, 0);
          check("t5_valid_async", pix_valid, 0);
          check("t5_data_async", pix_data, 0);
          check("t5_flags_async", {pix_sof, pix_eol, frame_done, overflow, frame_err}, 0);
        end
        cyc(c != 0, vd, (c == 0) ? 14'd0 : 14'(c - 1 + 16 * r));
        arm = 1'b0;
        rst = 1'b1;
        if (mode == 4 && r == 2 && c == 3) check("t3_ovf_before_5th", overflow, 0);
        if (mode == 4 && r == 2 && c == 4) check("t3_ovf_at_5th", overflow, 1);
      end
    end
    repeat (6) cyc(1'b1, 1'b1, 14'd0);
  endtask

  initial begin
    exp_tab = '{18'h20012, 18'h00013, 18'h00014, 18'h10015,
                18'h00022, 18'h00023, 18'h00024, 18'h10025};
    rst = 1'b0; arm = 1'b0; pix_ready = 1'b1; clr_err = 1'b0;
    afe_hd = 1'b1; afe_vd = 1'b1; afe_d = '0;
    done_cnt = 0; valid_seen = 0; busy_seen = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", pix_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 14'd0);

    // basic capture
    got_q.delete(); done_cnt = 0;
    run_frame(1'b1, 0);
    check("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check($sformatf("t1_word%0d", i), got_q[i], exp_tab[i]);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_busy_after", busy, 0);

    // syncs without arm
    valid_seen = 0; busy_seen = 0;
    run_frame(1'b0, 0);
    check("t2_unarmed_valid", valid_seen, 0);
    check("t2_unarmed_busy", busy_seen, 0);

    // arm inside a frame is ignored
    got_q.delete(); done_cnt = 0;
    run_frame(1'b1, 1);
    run_frame(1'b0, 0);
    check("t2_rearm_count", got_q.size(), 8);
    check("t2_rearm_done", done_cnt, 1);

    // backpressure and overflow
    got_q.delete(); done_cnt = 0;
    pix_ready = 1'b0;
    run_frame(1'b1, 4);
    check("t3_done_pulses", done_cnt, 1);
    check("t3_ovf_sticky", overflow, 1);
    check("t3_valid_held", pix_valid, 1);
    check("t3_head", {pix_sof, pix_eol, pix_data}, exp_tab[0]);
    repeat (3) cyc(1'b1, 1'b1, 14'd0);
    check("t3_head_stable", {pix_sof, pix_eol, pix_data}, exp_tab[0]);
    pix_ready = 1'b1;
    repeat (8) cyc(1'b1, 1'b1, 14'd0);
    check("t3_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("t3_drain%0d", i), got_q[i], exp_tab[i]);
    check("t3_empty", pix_valid, 0);
    check("t3_hold_last", {pix_sof, pix_eol, pix_data}, exp_tab[3]);
    clr_err = 1'b1;
    cyc(1'b1, 1'b1, 14'd0);
    clr_err = 1'b0;
    check("t3_ovf_cleared", overflow, 0);

    // VD abort mid-window
    done_cnt = 0;
    pix_ready = 1'b0;
    run_frame(1'b1, 2);
    check("t4_ferr", frame_err, 1);
    check("t4_busy", busy, 0);
    check("t4_no_done", done_cnt, 0);
    check("t4_fifo_kept", pix_valid, 1);
    check("t4_fifo_head", {pix_sof, pix_eol, pix_data}, exp_tab[0]);
    clr_err = 1'b1;
    cyc(1'b1, 1'b1, 14'd0);
    clr_err = 1'b0;
    cyc(1'b1, 1'b1, 14'd0);
    check("t4_ferr_cleared", frame_err, 0);
    pix_ready = 1'b1;
    repeat (6) cyc(1'b1, 1'b1, 14'd0);

    // reset mid-frame, then a clean capture
    run_frame(1'b1, 3);
    check("t5_idle_after_rst", busy, 0);
    got_q.delete(); done_cnt = 0;
    run_frame(1'b1, 0);
    check("t5_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check($sformatf("t5_word%0d", i), got_q[i], exp_tab[i]);
    check("t5_done_pulses", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
